sz_inner_decomp: RTL and testbench
==================================

// Module: sz_inner_decomp
// PURPOSE
//  Inverse of the SZ first-stage encoder: rebuilds the sample stream from the per-sample
//  (type code, quantization code, raw value) triples that the encoder emits.
//  Sits at the front of the decompression path, ahead of fixed-to-float conversion.
//  Keeps a 3-deep history of reconstructed samples and redoes the encoder's curve-fit prediction.
//  Samples are signed fixed-point; float conversion is handled outside this block.
// PARAMETERS
//  DW        32    sample width, two's complement
//  QW        10    quantization code width
//  RADIUS    512   quantization code offset; residual = qcode - RADIUS
//  STEP      2     reconstruction step in sample LSBs (2*error bound); constant
//  BLOCK_LEN 1024  samples per block; history clears at every block start
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   input triple valid
//  in_ready   out  1   block accepts input this cycle
//  in_code    in   2   0=unpredictable, 1=preceding, 2=linear, 3=quadratic fit
//  in_qcode   in   QW  quantization code; used when in_code!=0
//  in_raw     in   DW  verbatim sample; used when in_code==0 or on error
//  out_valid  out  1   reconstructed sample valid
//  out_ready  in   1   downstream accepts
//  out_data   out  DW  reconstructed sample
//  out_last   out  1   out_data is the final sample of a block
//  err        out  1   sticky: in_code!=0 received with in_qcode==0
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_last=0, err=0, history h1=h2=h3=0, sample count=0.
//  Reset clears everything mid-operation, including any held output; no partial state survives.
//  Handshake: in_ready = !out_valid | out_ready. A transfer occurs when in_valid & in_ready.
//  Latency: 1 cycle. An accepted triple sets out_valid and loads out_data on the next edge.
//  Output stability: out_valid/out_data/out_last stay unchanged while out_valid & !out_ready.
//  out_valid falls after an output handshake only if no new input was accepted on that edge.
//  Prediction, in signed DW+4 bits, from history h1 (newest), h2, h3:
//   code1 pred=h1; code2 pred=2*h1-h2; code3 pred=3*h1-3*h2+h3.
//  Reconstruction: rec = pred + ($signed({1'b0,qcode}) - RADIUS) * STEP.
//   rec saturates to [-2^(DW-1), 2^(DW-1)-1].
//  Unpredictable (code0): rec = in_raw, unmodified.
//  Error (code!=0, qcode==0): rec = in_raw and err sets; err stays set until reset.
//  History: on every accept, h3<=h2, h2<=h1, h1<=rec. out_data=rec.
//  Block boundary: a counter runs 0..BLOCK_LEN-1 and advances on every accept.
//   At count==0, history reads as zero for prediction, so code1 predicts 0.
//   out_last=1 on the output whose count==BLOCK_LEN-1; the count then wraps to 0.
//  Stalled cycles (no accept) change neither history nor count.
// TESTING (STEP=2, RADIUS=512, BLOCK_LEN=8 unless noted)
//  1 chain: (0,-,100),(1,515),(2,512),(3,511) -> out 100,106,112,116 on consecutive cycles.
//  2 saturate: h1=0x7FFFFFF0 then (1,1023) -> out 0x7FFFFFFF.
//    h1=0x80000010 then (1,0x001) -> out 0x80000000.
//  3 block: 8 accepts -> out_last=1 on the 8th only; 9th (1,513) -> out 2, history cleared.
//  4 backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0.
//    out_data is held and the count is frozen; after release the sequence matches scenario 1.
//  5 error: (2,0,raw=0x3E702C81) -> out 0x3E702C81 and err=1.
//    err stays 1 through later valid triples.
//  6 reset mid-stream: assert rst while out_valid=1 -> out_valid=0 and err=0 immediately.
//    Next (1,512) -> out 0.

Source files
------------

// File: rtl/sz_inner_decomp_if.sv
// Stream bundle for the SZ first-stage decoder: encoded triples in, samples out.
// The master side feeds triples and accepts samples; the slave side is the decoder.
interface sz_inner_decomp_if #(
    parameter int DW = 32,
    parameter int QW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_code;
    logic [QW-1:0] in_qcode;
    logic [DW-1:0] in_raw;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err;

    modport master (
        output in_valid, in_code, in_qcode, in_raw, out_ready,
        input  in_ready, out_valid, out_data, out_last, err
    );

    modport slave (
        input  in_valid, in_code, in_qcode, in_raw, out_ready,
        output in_ready, out_valid, out_data, out_last, err
    );
endinterface

// File: rtl/sz_inner_decomp.sv
// SZ first-stage decoder: redoes the encoder's curve-fit prediction from a 3-deep
// history and adds the dequantized residual, one sample per accepted triple.
module sz_inner_decomp #(
    parameter int DW        = 32,
    parameter int QW        = 10,
    parameter int RADIUS    = 512,
    parameter int STEP      = 2,
    parameter int BLOCK_LEN = 1024
) (
    input  logic             clk,
    input  logic             rst,
    sz_inner_decomp_if.slave bus
);
    localparam int W  = DW + 4;
    localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    localparam logic signed [W-1:0]  RADIUS_W = W'(RADIUS);
    localparam logic signed [W-1:0]  STEP_W   = W'(STEP);
    localparam logic signed [W-1:0]  SAT_MAX  = {{(W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [W-1:0]  SAT_MIN  = {{(W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]        MAX_DW   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        MIN_DW   = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0]        LAST_CNT = CW'(BLOCK_LEN - 1);

    logic [DW-1:0]        hist_reg [1:3];
    logic [DW-1:0]        hist_eff [1:3];
    logic signed [W-1:0]  hist_w   [1:3];

    logic [CW-1:0]        count_reg;
    logic [CW-1:0]        count_next;
    logic                 out_valid_reg;
    logic [DW-1:0]        out_data_reg;
    logic                 out_last_reg;
    logic                 err_reg;

    logic                 accept;
    logic                 block_start;
    logic                 is_last;
    logic                 qerr;
    logic                 use_raw;
    logic signed [W-1:0]  pred;
    logic signed [W-1:0]  qcode_w;
    logic signed [W-1:0]  resid;
    logic signed [W-1:0]  sum;
    logic [DW-1:0]        rec_fit;
    logic [DW-1:0]        rec_next;

    assign bus.in_ready  = !out_valid_reg || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign block_start   = (count_reg == '0);
    assign is_last       = (count_reg == LAST_CNT);
    assign count_next    = is_last ? '0 : count_reg + 1'b1;

    // The first sample of a block must not see the previous block's history.
    genvar gi;
    generate
        for (gi = 1; gi <= 3; gi++) begin : g_hist
            assign hist_eff[gi] = block_start ? '0 : hist_reg[gi];
            assign hist_w[gi]   = {{(W-DW){hist_eff[gi][DW-1]}}, hist_eff[gi]};
        end
    endgenerate

    always_comb begin
        pred = '0;
        case (bus.in_code)
            2'd1:    pred = hist_w[1];
            2'd2:    pred = (hist_w[1] <<< 1) - hist_w[2];
            2'd3:    pred = (hist_w[1] <<< 1) + hist_w[1]
                          - (hist_w[2] <<< 1) - hist_w[2] + hist_w[3];
            default: pred = '0;
        endcase
    end

    assign qcode_w = {{(W-QW){1'b0}}, bus.in_qcode};
    assign resid   = (qcode_w - RADIUS_W) * STEP_W;
    assign sum     = pred + resid;

    always_comb begin
        rec_fit = sum[DW-1:0];
        if (sum > SAT_MAX) begin
            rec_fit = MAX_DW;
        end else if (sum < SAT_MIN) begin
            rec_fit = MIN_DW;
        end
    end

    // qcode 0 is reserved by the encoder; such triples fall back to the raw value.
    assign qerr     = (bus.in_code != 2'd0) && (bus.in_qcode == '0);
    assign use_raw  = (bus.in_code == 2'd0) || qerr;
    assign rec_next = use_raw ? bus.in_raw : rec_fit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg[1]   <= '0;
            hist_reg[2]   <= '0;
            hist_reg[3]   <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if (accept) begin
                hist_reg[1]   <= rec_next;
                hist_reg[2]   <= hist_eff[1];
                hist_reg[3]   <= hist_eff[2];
                count_reg     <= count_next;
                out_valid_reg <= 1'b1;
                out_data_reg  <= rec_next;
                out_last_reg  <= is_last;
                if (qerr) begin
                    err_reg <= 1'b1;
                end
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_sz_inner_decomp.sv
// Directed bench for sz_inner_decomp with BLOCK_LEN=8: chain, saturation, block wrap,
// backpressure, error flag and mid-stream reset, each against hand-computed values.
module tb_sz_inner_decomp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cnt   = 0;

    always #5 clk = ~clk;

    sz_inner_decomp_if #(.DW(32), .QW(10)) bus ();

    sz_inner_decomp #(
        .DW(32), .QW(10), .RADIUS(512), .STEP(2), .BLOCK_LEN(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
    endtask

    // One triple accepted on the next edge; output checked 1 time unit later.
    task automatic send(input string tag, input logic [1:0] code, input logic [9:0] q,
                        input logic [31:0] raw, input logic [31:0] exp);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_code   = code;
        bus.in_qcode  = q;
        bus.in_raw    = raw;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        $display("tx %s code=%0d q=%0d raw=%h -> out=%h last=%0b err=%0b",
                 tag, code, q, raw, bus.out_data, bus.out_last, bus.err);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_data"},  bus.out_data, exp);
        chk({tag, "_last"},  {31'b0, bus.out_last}, {31'b0, (cnt == 7)});
        cnt = (cnt == 7) ? 0 : cnt + 1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_code   = 2'd0;
        bus.in_qcode  = 10'd0;
        bus.in_raw    = 32'd0;
        bus.out_ready = 1'b1;

        // reset state
        do_reset();
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_data",  bus.out_data, 32'd0);
        chk("rst_last",  {31'b0, bus.out_last}, 32'd0);
        chk("rst_err",   {31'b0, bus.err}, 32'd0);
        chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);

        // chain of all four codes
        send("chain0", 2'd0, 10'd0,   32'd100, 32'd100);
        send("chain1", 2'd1, 10'd515, 32'd0,   32'd106);
        send("chain2", 2'd2, 10'd512, 32'd0,   32'd112);
        send("chain3", 2'd3, 10'd511, 32'd0,   32'd116);
        idle();
        @(posedge clk); #1;
        chk("drain_valid", {31'b0, bus.out_valid}, 32'd0);

        // saturation both ways
        do_reset();
        send("satp_seed", 2'd0, 10'd0,    32'h7FFF_FFF0, 32'h7FFF_FFF0);
        send("satp",      2'd1, 10'd1023, 32'd0,         32'h7FFF_FFFF);
        send("satn_seed", 2'd0, 10'd0,    32'h8000_0010, 32'h8000_0010);
        send("satn",      2'd1, 10'd1,    32'd0,         32'h8000_0000);
        idle();

        // block wrap: last on the 8th, history cleared for the 9th
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send($sformatf("blk%0d", i), 2'd0, 10'd0, 32'(10 * (i + 1)), 32'(10 * (i + 1)));
        end
        send("blk8", 2'd1, 10'd513, 32'd0, 32'd2);
        send("blk9", 2'd2, 10'd512, 32'd0, 32'd4);
        idle();

        // backpressure: held output, frozen count
        do_reset();
        send("bp0", 2'd0, 10'd0, 32'd100, 32'd100);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_code   = 2'd1;
        bus.in_qcode  = 10'd515;
        bus.in_raw    = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            $display("tx stall%0d in_ready=%0b out=%h", i, bus.in_ready, bus.out_data);
            chk($sformatf("stall%0d_ready", i), {31'b0, bus.in_ready}, 32'd0);
            chk($sformatf("stall%0d_valid", i), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("stall%0d_data", i),  bus.out_data, 32'd100);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        $display("tx bp1 released -> out=%h", bus.out_data);
        chk("bp1_data", bus.out_data, 32'd106);
        chk("bp1_last", {31'b0, bus.out_last}, 32'd0);
        cnt = cnt + 1;
        send("bp2", 2'd2, 10'd512, 32'd0, 32'd112);
        send("bp3", 2'd3, 10'd511, 32'd0, 32'd116);
        idle();

        // error: qcode 0 with a predictive code
        do_reset();
        send("err0", 2'd2, 10'd0, 32'h3E70_2C81, 32'h3E70_2C81);
        chk("err0_flag", {31'b0, bus.err}, 32'd1);
        send("err1", 2'd1, 10'd512, 32'd0, 32'h3E70_2C81);
        chk("err1_flag", {31'b0, bus.err}, 32'd1);
        send("err2", 2'd0, 10'd0, 32'd5, 32'd5);
        chk("err2_flag", {31'b0, bus.err}, 32'd1);

        // asynchronous reset while an output is held
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        $display("tx async_rst out_valid=%0b err=%0b", bus.out_valid, bus.err);
        chk("arst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("arst_err",   {31'b0, bus.err}, 32'd0);
        chk("arst_data",  bus.out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cnt = 0;
        send("arst_next", 2'd1, 10'd512, 32'd0, 32'd0);
        chk("arst_next_err", {31'b0, bus.err}, 32'd0);
        idle();

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
